// File: rtl/prog_loader_pkg.sv
// Shared types, bus widths and ROM contents for the program loader.
package prog_loader_pkg;

    localparam int INST_W    = 12;
    localparam int REG_W     = 4;
    localparam int IDX_W     = 3;
    localparam int ROM_REGS  = 2;
    localparam int ROM_INSTS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_REG,
        S_GAP_R,
        S_LOAD_INST,
        S_GAP_I,
        S_STEP_HI,
        S_STEP_LO,
        S_FINISH
    } state_t;

    // Register-file init entry k targets register index k.
    function automatic logic [IDX_W-1:0] rom_reg_index(input int k);
        return (k >= 0 && k < ROM_REGS) ? IDX_W'(k) : '0;
    endfunction

    function automatic logic [REG_W-1:0] rom_reg_data(input int k);
        case (k)
            0:       return 4'd1;
            1:       return 4'd2;
            default: return '0;
        endcase
    endfunction

    function automatic logic [INST_W-1:0] rom_inst(input int w);
        case (w)
            0:       return 12'b001000000000;
            1:       return 12'b001000010001;
            2:       return 12'b000000100000;
            3:       return 12'b011011001000;
            4:       return 12'b010100011010;
            5:       return 12'b100101000011;
            6:       return 12'b101001001110;
            7:       return 12'b110000000111;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/prog_rom.sv
// Combinational lookup of register-file init entries and instruction words.
module prog_rom
    import prog_loader_pkg::*;
#(
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0]  i_reg_k,
    input  logic [SEL_W-1:0]  i_inst_w,
    output logic [IDX_W-1:0]  o_reg_index,
    output logic [REG_W-1:0]  o_reg_data,
    output logic [INST_W-1:0] o_inst
);

    always_comb begin
        o_reg_index = rom_reg_index(int'(i_reg_k));
        o_reg_data  = rom_reg_data(int'(i_reg_k));
        o_inst      = rom_inst(int'(i_inst_w));
    end

endmodule

// File: rtl/prog_loader.sv
// Loads register-file and instruction ROM into a controller, then steps it.
// Optional PROG_LOADER_SINGLE_STEP_EN: each step waits for a step_req pulse.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int HOLD     = 3,
    parameter int STEP_HI  = 3,
    parameter int STEP_LO  = 50,
    parameter int NUM_INST = 8,
    parameter int NUM_REGS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef PROG_LOADER_SINGLE_STEP_EN
    input  logic              step_req,
`endif
    output logic [INST_W-1:0] external,
    output logic [REG_W-1:0]  external_reg_file_data,
    output logic [IDX_W-1:0]  external_reg_file_index,
    output logic              is_external,
    output logic              load_to_reg_file,
    output logic              load_to_inst_mem,
    output logic              next_inst,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX  = (HOLD > STEP_HI) ? ((HOLD > STEP_LO) ? HOLD : STEP_LO)
                                               : ((STEP_HI > STEP_LO) ? STEP_HI : STEP_LO);
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int ITEM_MAX = (NUM_INST > NUM_REGS) ? NUM_INST : NUM_REGS;
    localparam int ITEM_W   = $clog2(ITEM_MAX + 1);

    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0]  SHI_LAST  = CNT_W'(STEP_HI - 1);
    localparam logic [ITEM_W-1:0] REG_LAST  = ITEM_W'(NUM_REGS - 1);
    localparam logic [ITEM_W-1:0] INST_LAST = ITEM_W'(NUM_INST - 1);
`ifndef PROG_LOADER_SINGLE_STEP_EN
    localparam logic [CNT_W-1:0]  SLO_LAST  = CNT_W'(STEP_LO - 1);
`endif

    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic [ITEM_W-1:0]   r_item, w_item_next;
    logic [INST_W-1:0]   r_external;
    logic [REG_W-1:0]    r_rf_data;
    logic [IDX_W-1:0]    r_rf_index;
    logic [INST_W-1:0]   w_rom_inst;
    logic [REG_W-1:0]    w_rom_data;
    logic [IDX_W-1:0]    w_rom_index;

    // Looked up with the next item so the bus changes on the edge the hold counter wraps.
    prog_rom #(.SEL_W(ITEM_W)) u_rom (
        .i_reg_k     (w_item_next),
        .i_inst_w    (w_item_next),
        .o_reg_index (w_rom_index),
        .o_reg_data  (w_rom_data),
        .o_inst      (w_rom_inst)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_item  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_item  <= w_item_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + CNT_W'(1);
        w_item_next  = r_item;
        case (r_state)
            S_IDLE: begin
                w_cnt_next  = '0;
                w_item_next = '0;
                if (start) w_state_next = S_LOAD_REG;
            end
            S_LOAD_REG: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_next = '0;
                    if (r_item == REG_LAST) begin
                        w_item_next  = '0;
                        w_state_next = S_GAP_R;
                    end else begin
                        w_item_next = r_item + ITEM_W'(1);
                    end
                end
            end
            S_GAP_R: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = S_LOAD_INST;
                end
            end
            S_LOAD_INST: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_next = '0;
                    if (r_item == INST_LAST) begin
                        w_item_next  = '0;
                        w_state_next = S_GAP_I;
                    end else begin
                        w_item_next = r_item + ITEM_W'(1);
                    end
                end
            end
            S_GAP_I: begin
`ifdef PROG_LOADER_SINGLE_STEP_EN
                if (r_cnt >= HOLD_LAST) begin
                    w_cnt_next = r_cnt;
                    if (step_req) begin
                        w_cnt_next   = '0;
                        w_state_next = S_STEP_HI;
                    end
                end
`else
                if (r_cnt == HOLD_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = S_STEP_HI;
                end
`endif
            end
            S_STEP_HI: begin
                if (r_cnt == SHI_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = S_STEP_LO;
                end
            end
            S_STEP_LO: begin
`ifdef PROG_LOADER_SINGLE_STEP_EN
                w_cnt_next = '0;
                if (r_item == INST_LAST) begin
                    w_item_next  = '0;
                    w_state_next = S_FINISH;
                end else if (step_req) begin
                    w_item_next  = r_item + ITEM_W'(1);
                    w_state_next = S_STEP_HI;
                end
`else
                if (r_cnt == SLO_LAST) begin
                    w_cnt_next = '0;
                    if (r_item == INST_LAST) begin
                        w_item_next  = '0;
                        w_state_next = S_FINISH;
                    end else begin
                        w_item_next  = r_item + ITEM_W'(1);
                        w_state_next = S_STEP_HI;
                    end
                end
`endif
            end
            S_FINISH: begin
                w_cnt_next   = '0;
                w_item_next  = '0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_cnt_next   = '0;
                w_item_next  = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Bus values persist through gaps and idle until reloaded or reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_external <= '0;
            r_rf_data  <= '0;
            r_rf_index <= '0;
        end else begin
            if (w_state_next == S_LOAD_REG) begin
                r_rf_data  <= w_rom_data;
                r_rf_index <= w_rom_index;
            end
            if (w_state_next == S_LOAD_INST) begin
                r_external <= w_rom_inst;
            end
        end
    end

    assign external                = r_external;
    assign external_reg_file_data  = r_rf_data;
    assign external_reg_file_index = r_rf_index;
    assign is_external             = 1'b0;
    assign load_to_reg_file        = (r_state == S_LOAD_REG);
    assign load_to_inst_mem        = (r_state == S_LOAD_INST);
    assign next_inst               = (r_state == S_STEP_HI);
    assign busy                    = (r_state != S_IDLE);
    assign done                    = (r_state == S_FINISH);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench: directed timing spots plus random start/reset against a cycle-offset model.
module tb_prog_loader;

    localparam int HOLD  = 3;
    localparam int SHI   = 3;
    localparam int SLO   = 50;
    localparam int NI    = 8;
    localparam int NR    = 2;
    localparam int T_GR  = NR * HOLD;
    localparam int T_LI  = T_GR + HOLD;
    localparam int T_GI  = T_LI + NI * HOLD;
    localparam int T_ST  = T_GI + HOLD;
    localparam int T_FIN = T_ST + NI * (SHI + SLO);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] external;
    logic [3:0]  external_reg_file_data;
    logic [2:0]  external_reg_file_index;
    logic        is_external, load_to_reg_file, load_to_inst_mem, next_inst, busy, done;
`ifdef PROG_LOADER_SINGLE_STEP_EN
    logic        step_req = 1'b1;
`endif

    always #5 clk = ~clk;

    prog_loader #(
        .HOLD(HOLD), .STEP_HI(SHI), .STEP_LO(SLO), .NUM_INST(NI), .NUM_REGS(NR)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
`ifdef PROG_LOADER_SINGLE_STEP_EN
        .step_req                (step_req),
`endif
        .external                (external),
        .external_reg_file_data  (external_reg_file_data),
        .external_reg_file_index (external_reg_file_index),
        .is_external             (is_external),
        .load_to_reg_file        (load_to_reg_file),
        .load_to_inst_mem        (load_to_inst_mem),
        .next_inst               (next_inst),
        .busy                    (busy),
        .done                    (done)
    );

    logic [11:0] tb_inst [8] = '{12'b001000000000, 12'b001000010001, 12'b000000100000,
                                 12'b011011001000, 12'b010100011010, 12'b100101000011,
                                 12'b101001001110, 12'b110000000111};
    logic [3:0]  tb_reg_data [2] = '{4'd1, 4'd2};

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int rises = 0;
    logic prev_ni = 1'b0;

    // Model: m_t is the cycle offset since the first LOAD_REG cycle, -1 when idle.
    int          m_t = -1;
    logic [11:0] m_ext = '0;
    logic [3:0]  m_data = '0;
    logic [2:0]  m_idx = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic st);
        if (rst) begin
            m_t = -1; m_ext = '0; m_data = '0; m_idx = '0;
        end else if (m_t < 0) begin
            if (st) m_t = 0;
        end else begin
            m_t = m_t + 1;
            if (m_t > T_FIN) m_t = -1;
        end
        if (m_t >= 0 && m_t < T_GR) begin
            m_idx  = 3'(m_t / HOLD);
            m_data = tb_reg_data[m_t / HOLD];
        end
        if (m_t >= T_LI && m_t < T_GI) m_ext = tb_inst[(m_t - T_LI) / HOLD];
    endtask

    function automatic logic [24:0] model_out();
        logic lr, li, ni, bz, dn;
        lr = (m_t >= 0) && (m_t < T_GR);
        li = (m_t >= T_LI) && (m_t < T_GI);
        ni = (m_t >= T_ST) && (m_t < T_FIN) && (((m_t - T_ST) % (SHI + SLO)) < SHI);
        bz = (m_t >= 0);
        dn = (m_t == T_FIN);
        return {m_ext, m_data, m_idx, lr, li, ni, bz, dn, 1'b0};
    endfunction

    function automatic logic [24:0] dut_out();
        return {external, external_reg_file_data, external_reg_file_index, load_to_reg_file,
                load_to_inst_mem, next_inst, busy, done, is_external};
    endfunction

    task automatic tick(input logic rst, input logic st);
        reset = rst;
        start = st;
        model_step(rst, st);
        @(negedge clk);
        cyc++;
        $display("cyc=%0d rst=%0b start=%0b out=%07h model=%07h", cyc, rst, st, dut_out(), model_out());
        check("outputs", 32'(dut_out()), 32'(model_out()));
        check("mutex", 32'((32'(load_to_reg_file) + 32'(load_to_inst_mem) + 32'(next_inst)) <= 1), 32'd1);
    endtask

    task automatic spot1();
        if (next_inst && !prev_ni) rises++;
        prev_ni = next_inst;
        case (cyc)
            1:   begin check("c1_lr", 32'(load_to_reg_file), 32'd1);
                       check("c1_idx_data", 32'({external_reg_file_index, external_reg_file_data}), 32'h01); end
            3:   check("c3_idx_data", 32'({external_reg_file_index, external_reg_file_data}), 32'h01);
            4:   check("c4_idx_data", 32'({external_reg_file_index, external_reg_file_data}), 32'h12);
            6:   check("c6_lr", 32'(load_to_reg_file), 32'd1);
            7:   begin check("c7_lr", 32'(load_to_reg_file), 32'd0);
                       check("c7_data_hold", 32'(external_reg_file_data), 32'd2); end
            10:  begin check("c10_li", 32'(load_to_inst_mem), 32'd1);
                       check("c10_ext", 32'(external), 32'h200); end
            13:  check("c13_ext", 32'(external), 32'h211);
            31:  check("c31_ext", 32'(external), 32'hC07);
            33:  check("c33_li", 32'(load_to_inst_mem), 32'd1);
            34:  check("c34_li", 32'(load_to_inst_mem), 32'd0);
            36:  check("c36_ni", 32'(next_inst), 32'd0);
            37:  check("c37_ni", 32'(next_inst), 32'd1);
            40:  check("c40_ni", 32'(next_inst), 32'd0);
            90:  check("c90_ni", 32'(next_inst), 32'd1);
            460: check("c460_done", 32'(done), 32'd0);
            461: check("c461_done_busy", 32'({done, busy}), 32'd3);
            462: check("c462_idle", 32'({done, busy}), 32'd0);
            default: ;
        endcase
    endtask

    initial begin
        repeat (3) @(negedge clk);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("reset_state", 32'(dut_out()), 32'd0);

        // Nominal run, start pulse at cycle 0.
        cyc = 0;
        tick(1'b0, 1'b1);
        spot1();
        while (cyc < 465) begin
            tick(1'b0, 1'b0);
            spot1();
        end
        check("ni_pulses", 32'(rises), 32'd8);

        // Reset during LOAD_INST, then restart.
        tick(1'b1, 1'b0);
        cyc = 0;
        tick(1'b0, 1'b1);
        while (cyc < 20) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check("c21_zero", 32'(dut_out()), 32'd0);
        while (cyc < 25) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("c26_restart", 32'({load_to_reg_file, external_reg_file_index, external_reg_file_data}), 32'h81);
        while (cyc < 26 + T_FIN + 2) tick(1'b0, 1'b0);

        // start held high through busy and FINISH.
        tick(1'b1, 1'b0);
        cyc = 0;
        tick(1'b0, 1'b1);
        while (cyc < 470) begin
            tick(1'b0, 1'b1);
            if (cyc == 462) check("held_idle", 32'(busy), 32'd0);
            if (cyc == 463) check("held_restart", 32'(load_to_reg_file), 32'd1);
        end

        // Random start and occasional reset.
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 5));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
